// File: rtl/xrs2_pkg.sv
// Shared definitions for the xrs2 register file: write/extension codes,
// sequencer state encoding and the write-data extension function.
package xrs2_pkg;

  localparam logic [2:0] XRS2_RWE_NONE = 3'd0;
  localparam logic [2:0] XRS2_RWE_S8   = 3'd1;
  localparam logic [2:0] XRS2_RWE_S16  = 3'd2;
  localparam logic [2:0] XRS2_RWE_S32  = 3'd3;
  localparam logic [2:0] XRS2_RWE_S64  = 3'd4;
  localparam logic [2:0] XRS2_RWE_U8   = 3'd5;
  localparam logic [2:0] XRS2_RWE_U16  = 3'd6;
  localparam logic [2:0] XRS2_RWE_U32  = 3'd7;

  localparam int XRS2_XLEN_MAX = 64;

  typedef enum logic {
    XRS2_CLEAR = 1'b0,
    XRS2_RUN   = 1'b1
  } xrs2_state_e;

  // Result is computed at the widest XLEN; a 32-bit instance keeps the low
  // half, which makes S32/U32/S64 all pass rdat_i through unchanged.
  function automatic logic [XRS2_XLEN_MAX-1:0] extend(
    input logic [2:0]               code,
    input logic [XRS2_XLEN_MAX-1:0] data
  );
    logic [XRS2_XLEN_MAX-1:0] res;
    res = '0;
    case (code)
      XRS2_RWE_S8:  res = {{56{data[7]}},  data[7:0]};
      XRS2_RWE_S16: res = {{48{data[15]}}, data[15:0]};
      XRS2_RWE_S32: res = {{32{data[31]}}, data[31:0]};
      XRS2_RWE_S64: res = data;
      XRS2_RWE_U8:  res = {56'd0, data[7:0]};
      XRS2_RWE_U16: res = {48'd0, data[15:0]};
      XRS2_RWE_U32: res = {32'd0, data[31:0]};
      default:      res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/xrs2_bank.sv
// One NREG x XLEN block-RAM bank: single write port, registered read-first
// read port, no reset (contents are initialised by the top-level clear).
module xrs2_bank #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic            clk_i,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr,
  output logic [XLEN-1:0] rdata
);

  logic [XLEN-1:0] mem [NREG];

  always_ff @(posedge clk_i) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/xrs2.sv
// Integer register file: NRP registered read ports, one extending write port,
// optional hardwired r0, write-first bypass and a post-reset clear sequencer.
module xrs2
  import xrs2_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter int NREG     = 32,
  parameter int NRP      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NREG)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [AW-1:0]       rd_i,
  input  logic [XLEN-1:0]     rdat_i,
  input  logic [2:0]          rwe_i,
  input  logic [NRP*AW-1:0]   ra_i,
  output logic [NRP*XLEN-1:0] rdat_o,
  output logic                busy_o
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(NREG - 1);

  xrs2_state_e      state_reg;
  logic [AW-1:0]    cnt_reg;
  logic             busy_reg;
  logic [XLEN-1:0]  byp_data_reg;

  logic                     clearing;
  logic                     ext_we;
  logic                     wr_en;
  logic [AW-1:0]            wr_addr;
  logic [XLEN-1:0]          wr_data;
  logic [XRS2_XLEN_MAX-1:0] rdat_wide;
  logic [XRS2_XLEN_MAX-1:0] ext_wide;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= XRS2_CLEAR;
      cnt_reg   <= '0;
      busy_reg  <= 1'b1;
    end else begin
      case (state_reg)
        XRS2_CLEAR: begin
          cnt_reg <= cnt_reg + AW'(1);
          if (cnt_reg == LAST_ADDR) begin
            state_reg <= XRS2_RUN;
            busy_reg  <= 1'b0;
          end
        end
        XRS2_RUN: ;
        default: state_reg <= XRS2_CLEAR;
      endcase
    end
  end

  always_comb begin
    rdat_wide             = '0;
    rdat_wide[XLEN-1:0]   = rdat_i;
    ext_wide              = extend(rwe_i, rdat_wide);
    clearing              = (state_reg == XRS2_CLEAR);
    ext_we                = !clearing && (rwe_i != XRS2_RWE_NONE) &&
                            !((ZERO_REG != 0) && (rd_i == '0));
    wr_en                 = clearing || ext_we;
    wr_addr               = clearing ? cnt_reg : rd_i;
    wr_data               = clearing ? '0 : ext_wide[XLEN-1:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      byp_data_reg <= '0;
    end else begin
      byp_data_reg <= wr_data;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NRP; gi++) begin : g_port
      logic [AW-1:0]   ra;
      logic [AW-1:0]   ra_reg;
      logic            byp_reg;
      logic [XLEN-1:0] bank_q;

      assign ra = ra_i[gi*AW +: AW];

      xrs2_bank #(
        .XLEN (XLEN),
        .NREG (NREG),
        .AW   (AW)
      ) u_bank (
        .clk_i (clk_i),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata (wr_data),
        .raddr (ra),
        .rdata (bank_q)
      );

      // Clear writes always bypass: the final clear edge may sample the
      // register being zeroed, whose RAM contents are still undefined.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          ra_reg  <= '0;
          byp_reg <= 1'b0;
        end else begin
          ra_reg  <= ra;
          byp_reg <= wr_en && (clearing || (BYPASS != 0)) && (wr_addr == ra);
        end
      end

      assign rdat_o[gi*XLEN +: XLEN] =
        (busy_reg || ((ZERO_REG != 0) && (ra_reg == '0))) ? '0 :
        byp_reg ? byp_data_reg : bank_q;
    end
  endgenerate

  assign busy_o = busy_reg;

endmodule

// File: tb/tb_xrs2.sv
// Bench for xrs2: default build, a read-first build and a 32-bit/16-entry/
// 3-port build, all checked against array models of the register contents.
module tb_xrs2;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  logic [4:0]   rd_ab;
  logic [63:0]  rdat_ab;
  logic [2:0]   rwe_ab;
  logic [9:0]   ra_ab;
  logic [127:0] rdat_a, rdat_b;
  logic         busy_a, busy_b;

  logic [3:0]   rd_c;
  logic [31:0]  rdat_c;
  logic [2:0]   rwe_c;
  logic [11:0]  ra_c;
  logic [95:0]  rdat_cq;
  logic         busy_c;

  int checks = 0;
  int errors = 0;

  logic [63:0] m_ab [32];
  logic [31:0] m_c  [16];
  logic [63:0] ext_tbl [8];

  xrs2 #(.XLEN(64), .NREG(32), .NRP(2), .ZERO_REG(1), .BYPASS(1)) u_a (
    .clk_i(clk_i), .rst_i(rst_i), .rd_i(rd_ab), .rdat_i(rdat_ab), .rwe_i(rwe_ab),
    .ra_i(ra_ab), .rdat_o(rdat_a), .busy_o(busy_a));

  xrs2 #(.XLEN(64), .NREG(32), .NRP(2), .ZERO_REG(1), .BYPASS(0)) u_b (
    .clk_i(clk_i), .rst_i(rst_i), .rd_i(rd_ab), .rdat_i(rdat_ab), .rwe_i(rwe_ab),
    .ra_i(ra_ab), .rdat_o(rdat_b), .busy_o(busy_b));

  xrs2 #(.XLEN(32), .NREG(16), .NRP(3), .ZERO_REG(1), .BYPASS(1)) u_c (
    .clk_i(clk_i), .rst_i(rst_i), .rd_i(rd_c), .rdat_i(rdat_c), .rwe_i(rwe_c),
    .ra_i(ra_c), .rdat_o(rdat_cq), .busy_o(busy_c));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Extension rule: keep the low n bits; signed codes replicate bit n-1.
  function automatic logic [63:0] ext_model(input logic [2:0] code, input logic [63:0] d,
                                             input int xlen);
    int n;
    bit sgn;
    logic [63:0] mask, v;
    case (code)
      3'd1: begin n = 8;  sgn = 1; end
      3'd2: begin n = 16; sgn = 1; end
      3'd3: begin n = 32; sgn = 1; end
      3'd5: begin n = 8;  sgn = 0; end
      3'd6: begin n = 16; sgn = 0; end
      3'd7: begin n = 32; sgn = 0; end
      default: begin n = 64; sgn = 1; end
    endcase
    mask = (n == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << n) - 64'd1);
    v = d & mask;
    if (sgn && n < 64 && d[n-1]) v = v | ~mask;
    if (xlen == 32) v = v & 64'h0000_0000_FFFF_FFFF;
    return v;
  endfunction

  task automatic zero_models();
    for (int i = 0; i < 32; i++) m_ab[i] = '0;
    for (int i = 0; i < 16; i++) m_c[i] = '0;
  endtask

  // One clock of traffic: A/B driven by the caller, C randomised here.
  task automatic cycle();
    logic [63:0] ea [2];
    logic [63:0] eb [2];
    logic [31:0] ec [3];
    logic [63:0] wv;
    logic [31:0] wc;
    int a;
    rd_c   = 4'($urandom_range(0, 15));
    rdat_c = $urandom;
    rwe_c  = 3'($urandom_range(0, 7));
    for (int k = 0; k < 3; k++) ra_c[k*4 +: 4] = 4'($urandom_range(0, 15));
    wv = ext_model(rwe_ab, rdat_ab, 64);
    wc = 32'(ext_model(rwe_c, {32'd0, rdat_c}, 32));
    for (int k = 0; k < 2; k++) begin
      a = int'(ra_ab[k*5 +: 5]);
      eb[k] = (a == 0) ? 64'd0 : m_ab[a];
      ea[k] = (a != 0 && rwe_ab != 0 && int'(rd_ab) == a) ? wv : eb[k];
    end
    for (int k = 0; k < 3; k++) begin
      a = int'(ra_c[k*4 +: 4]);
      ec[k] = (a == 0) ? 32'd0 : (rwe_c != 0 && int'(rd_c) == a) ? wc : m_c[a];
    end
    @(posedge clk_i);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("A.rd%0d", k), 128'(rdat_a[k*64 +: 64]), 128'(ea[k]));
      chk($sformatf("B.rd%0d", k), 128'(rdat_b[k*64 +: 64]), 128'(eb[k]));
    end
    for (int k = 0; k < 3; k++)
      chk($sformatf("C.rd%0d", k), 128'(rdat_cq[k*32 +: 32]), 128'(ec[k]));
    chk("A.busy", 128'(busy_a), 128'(0));
    chk("C.busy", 128'(busy_c), 128'(0));
    if (rwe_ab != 0 && rd_ab != 0) m_ab[rd_ab] = wv;
    if (rwe_c != 0 && rd_c != 0) m_c[rd_c] = wc;
  endtask

  // Runs from reset release: busy must last exactly NREG edges and the
  // all-ones writes offered meanwhile must never land.
  task automatic do_clear();
    rwe_ab = 3'd4; rdat_ab = '1; rd_ab = 5'd5; ra_ab = {5'd5, 5'd31};
    rwe_c = 3'd4; rdat_c = '1; rd_c = 4'd5; ra_c = {4'd5, 4'd15, 4'd0};
    for (int t = 1; t <= 36; t++) begin
      @(posedge clk_i);
      #1;
      chk($sformatf("A.busy@%0d", t), 128'(busy_a), 128'(t < 32));
      chk($sformatf("B.busy@%0d", t), 128'(busy_b), 128'(t < 32));
      chk($sformatf("C.busy@%0d", t), 128'(busy_c), 128'(t < 16));
      chk($sformatf("A.clr@%0d", t), rdat_a, 128'(0));
      chk($sformatf("B.clr@%0d", t), rdat_b, 128'(0));
      chk($sformatf("C.clr@%0d", t), 128'(rdat_cq), 128'(0));
      if (t >= 32) rwe_ab = 3'd0;
      if (t >= 16) rwe_c = 3'd0;
    end
    zero_models();
  endtask

  initial begin
    ext_tbl[0] = 64'h0;
    ext_tbl[1] = 64'hFFFF_FFFF_FFFF_FF81;
    ext_tbl[2] = 64'hFFFF_FFFF_FFFF_8081;
    ext_tbl[3] = 64'h8081;
    ext_tbl[4] = 64'h8081;
    ext_tbl[5] = 64'h81;
    ext_tbl[6] = 64'h8081;
    ext_tbl[7] = 64'h8081;
    rst_i = 1'b1;
    rd_ab = '0; rdat_ab = '0; rwe_ab = '0; ra_ab = '0;
    rd_c = '0; rdat_c = '0; rwe_c = '0; ra_c = '0;
    zero_models();

    repeat (2) @(posedge clk_i);
    #3;
    chk("rst.A.busy", 128'(busy_a), 128'(1));
    chk("rst.B.busy", 128'(busy_b), 128'(1));
    chk("rst.C.busy", 128'(busy_c), 128'(1));
    chk("rst.A.rdat", rdat_a, 128'(0));
    chk("rst.B.rdat", rdat_b, 128'(0));
    chk("rst.C.rdat", 128'(rdat_cq), 128'(0));
    rst_i = 1'b0;
    do_clear();

    for (int i = 0; i < 32; i++) begin
      rwe_ab = 3'd0;
      ra_ab = {5'(31 - i), 5'(i)};
      cycle();
    end

    for (int code = 1; code < 8; code++) begin
      rd_ab = 5'd5; rdat_ab = 64'h8081; rwe_ab = 3'(code); ra_ab = {5'd5, 5'd5};
      cycle();
      rwe_ab = 3'd0;
      cycle();
      chk($sformatf("ext%0d.A", code), 128'(rdat_a[63:0]), 128'(ext_tbl[code]));
      chk($sformatf("ext%0d.B", code), 128'(rdat_b[127:64]), 128'(ext_tbl[code]));
    end

    rd_ab = 5'd0; rdat_ab = 64'hDEAD_BEEF; rwe_ab = 3'd4; ra_ab = '0;
    cycle();
    chk("r0.same_cycle", rdat_a, 128'(0));
    rwe_ab = 3'd0;
    cycle();
    chk("r0.after", rdat_a, 128'(0));

    rd_ab = 5'd7; rdat_ab = 64'h1; rwe_ab = 3'd4; ra_ab = '0;
    cycle();
    rdat_ab = 64'h55; ra_ab = {5'd7, 5'd7};
    cycle();
    chk("bypass.A", rdat_a, {64'h55, 64'h55});
    chk("bypass.B", rdat_b, {64'h1, 64'h1});
    rwe_ab = 3'd0;
    cycle();

    repeat (400) begin
      rd_ab = 5'($urandom_range(0, 31));
      rdat_ab = {$urandom, $urandom};
      rwe_ab = 3'($urandom_range(0, 7));
      ra_ab = 10'($urandom);
      if ($urandom_range(0, 3) == 0) ra_ab[($urandom_range(0, 1))*5 +: 5] = rd_ab;
      cycle();
    end

    rd_ab = 5'd3; rdat_ab = 64'h9; rwe_ab = 3'd4; ra_ab = {5'd3, 5'd3};
    cycle();
    rwe_ab = 3'd0;
    cycle();
    chk("r3.before_rst", 128'(rdat_a[63:0]), 128'(9));
    #2;
    rst_i = 1'b1;
    #1;
    chk("midrst.A.rdat", rdat_a, 128'(0));
    chk("midrst.A.busy", 128'(busy_a), 128'(1));
    chk("midrst.B.busy", 128'(busy_b), 128'(1));
    chk("midrst.C.rdat", 128'(rdat_cq), 128'(0));
    chk("midrst.C.busy", 128'(busy_c), 128'(1));
    @(posedge clk_i);
    #3;
    rst_i = 1'b0;
    do_clear();
    rwe_ab = 3'd0; ra_ab = {5'd3, 5'd3};
    cycle();
    chk("r3.after_rst", 128'(rdat_a[63:0]), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
